vector_sweep_compare: RTL

VECTOR_SWEEP_COMPARE -- requirements
Module: vector_sweep_compare

---
 rtl/vector_sweep_compare_pkg.sv | 14 +
 rtl/vector_sweep_compare_sig_accum.sv | 26 ++
 rtl/vector_sweep_compare.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vector_sweep_compare_pkg.sv
// Shared definitions for the exhaustive vector sweep comparator.
// Holds the FSM state type and the signature width.
package vector_sweep_compare_pkg;

  localparam int unsigned SIG_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/vector_sweep_compare_sig_accum.sv
// Rotate-and-xor signature accumulator over a stream of response words.
// Reusable by any checker that needs a compact response fingerprint.
module sweep_sig_accum
  import vector_sweep_compare_pkg::*;
#(
  parameter int unsigned DW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DW-1:0]    data,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clear) begin
      sig <= '0;
    end else if (enable) begin
      sig <= {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(data);
    end
  end

endmodule

// File: rtl/vector_sweep_compare.sv
// Walks stim through every AW-bit value, compares golden and DUT responses
// after a settle delay, and reports mismatch count, first failure and signature.
module vector_sweep_compare
  import vector_sweep_compare_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned YW     = 10,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [AW-1:0]    stim,
  input  logic [YW-1:0]    y_ref,
  input  logic [YW-1:0]    y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW:0]      mismatch_cnt,
  output logic             first_fail_valid,
  output logic [AW-1:0]    first_fail_vec,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW-1:0] STIM_LAST = '1;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] settle_cnt;
  logic          accept;
  logic          settle_end;
  logic          last_vec;
  logic          mismatch;

  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign settle_end = (settle_cnt == CW'(SETTLE - 1));
  assign last_vec   = (stim == STIM_LAST);
  assign mismatch   = |(y_ref ^ y_dut);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start)      state_nx = DRIVE;
      DRIVE:      if (settle_end) state_nx = SAMPLE;
      SAMPLE:     state_nx = last_vec ? DONE : DRIVE;
      default:    state_nx = IDLE;
    endcase
  end

  // Status decode; pass only looks at registered state and count
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state)
      DRIVE, SAMPLE: busy = 1'b1;
      DONE: begin
        done = 1'b1;
        pass = (mismatch_cnt == '0);
      end
      default: ;
    endcase
  end

  // Vector sequencing and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim             <= '0;
      settle_cnt       <= '0;
      mismatch_cnt     <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (accept) begin
      stim             <= '0;
      settle_cnt       <= '0;
      mismatch_cnt     <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      case (state)
        DRIVE: settle_cnt <= settle_end ? '0 : settle_cnt + CW'(1);
        SAMPLE: begin
          if (mismatch) begin
            mismatch_cnt <= mismatch_cnt + (AW + 1)'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= stim;
            end
          end
          // Final vector holds so the reported stim stays at all-ones
          if (!last_vec) stim <= stim + AW'(1);
        end
        default: ;
      endcase
    end
  end

  sweep_sig_accum #(
    .DW(YW)
  ) u_sig (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(state == SAMPLE),
    .data  (y_dut),
    .sig   (signature)
  );

endmodule
